// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin between the
// ALU and load-return paths, registered write outputs, and a busy scoreboard for loads.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic              sys_clock,
    input  logic              sys_reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              load_issue,
    input  logic [ADDR_W-1:0] load_issue_addr,
    input  logic [ADDR_W-1:0] check_addr0,
    input  logic [ADDR_W-1:0] check_addr1,
    output logic              hazard,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_addr_result,
    output logic [DATA_W-1:0] rf_data_write,
    output logic              wb_error
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic              last_grant_q, last_grant_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_q, err_d;
    logic              grant_alu, grant_mem;

    // Handshake: a requester's ready is its grant; a transfer happens on a rising edge where
    // valid && ready. Losers keep valid/addr/data stable, nothing is buffered, and no ready is
    // given while reset is asserted.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!sys_reset) begin
            if (alu_valid && mem_valid) begin
                grant_alu = (last_grant_q == GRANT_MEM);
                grant_mem = (last_grant_q == GRANT_ALU);
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    always_comb begin
        last_grant_d = last_grant_q;
        w_en_d       = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        busy_d       = busy_q;
        err_d        = err_q;

        if (grant_alu) begin
            last_grant_d = GRANT_ALU;
            w_en_d       = (alu_addr != '0);
            addr_d       = alu_addr;
            data_d       = alu_data;
        end else if (grant_mem) begin
            last_grant_d = GRANT_MEM;
            w_en_d       = (mem_addr != '0);
            addr_d       = mem_addr;
            data_d       = mem_data;
            busy_d[mem_addr] = 1'b0;
            if (mem_addr != '0 && !busy_q[mem_addr]) begin
                err_d = 1'b1;
            end
        end

        // Applied after the clear so a new load to the same register stays outstanding.
        if (load_issue && load_issue_addr != '0) begin
            busy_d[load_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            last_grant_q <= GRANT_MEM;
            w_en_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            w_en_q       <= w_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign hazard         = busy_q[check_addr0] | busy_q[check_addr1];
    assign rf_w_en        = w_en_q;
    assign rf_addr_result = addr_q;
    assign rf_data_write  = data_q;
    assign wb_error       = err_q;

endmodule
